shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_sign_cond.sv | 12 +
 rtl/shift_add_mult.sv | 103 ++++++++++
 tb/tb_shift_add_mult.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mult_state_t;

  // Bits needed to count 0..value-1; value is at least 2 here, so the result is at least 1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/mult_sign_cond.sv
// Conditional two's-complement negate, used for operand magnitudes and the final sign fix.
module mult_sign_cond #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: one add/shift per cycle on magnitudes, sign applied at the end.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] O,
  output logic               busy,
  output logic               Finish
);
  import mult_pkg::*;

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t state, next_state;

  logic [WIDTH-1:0]   amag, bmag_in, bmag;
  logic [2*WIDTH:0]   acc, acc_step;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      count;
  logic               negate_flag;
  logic [2*WIDTH-1:0] prod_fixed;

  // The most negative operand yields 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  mult_sign_cond #(.WIDTH(WIDTH)) u_amag (
    .value  (A),
    .negate (signed_mode & A[WIDTH-1]),
    .result (amag)
  );

  mult_sign_cond #(.WIDTH(WIDTH)) u_bmag (
    .value  (B),
    .negate (signed_mode & B[WIDTH-1]),
    .result (bmag_in)
  );

  mult_sign_cond #(.WIDTH(2*WIDTH)) u_fix (
    .value  (acc[2*WIDTH-1:0]),
    .negate (negate_flag),
    .result (prod_fixed)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (count == LAST) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Upper half never exceeds 2^WIDTH-1 before the add, so a WIDTH+1 bit sum cannot overflow.
  always_comb begin
    sum      = acc[2*WIDTH:WIDTH] + {1'b0, bmag};
    acc_step = acc[0] ? {1'b0, sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      bmag        <= '0;
      count       <= '0;
      negate_flag <= 1'b0;
      O           <= '0;
      Finish      <= 1'b0;
    end else begin
      Finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc         <= {{(WIDTH+1){1'b0}}, amag};
            bmag        <= bmag_in;
            negate_flag <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            count       <= '0;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= (count == LAST) ? '0 : count + CW'(1);
        end
        FIX: begin
          O      <= prod_fixed;
          Finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIX);

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and sweep checks of shift_add_mult at WIDTH=4 against hand values and a product model.
module tb_shift_add_mult;

  logic       clk;
  logic       reset;
  logic       start;
  logic       signed_mode;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] O;
  logic       busy;
  logic       Finish;

  int testsRun;
  int testsFailed;

  shift_add_mult #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .O           (O),
    .busy        (busy),
    .Finish      (Finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at the falling edge right after the start-sampling edge; k counts cycles after that edge.
  task automatic waitFinish(output int lat, output int busyCycles);
    lat = -1;
    busyCycles = 0;
    for (int k = 0; k <= 12 && lat < 0; k++) begin
      if (busy) busyCycles++;
      if (Finish) lat = k;
      else @(negedge clk);
    end
  endtask

  // Operands are scrambled right after the start edge to show they are captured, not followed.
  task automatic applyStimulus(input logic mode, input logic [3:0] a, input logic [3:0] b,
                               output logic [7:0] prod, output int lat, output int busyCycles);
    @(negedge clk);
    signed_mode = mode;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
    signed_mode = ~mode;
    waitFinish(lat, busyCycles);
    prod = O;
  endtask

  function automatic logic [7:0] modelProduct(input logic mode, input logic [3:0] a, input logic [3:0] b);
    int ea, eb;
    ea = (mode && a[3]) ? int'(a) - 16 : int'(a);
    eb = (mode && b[3]) ? int'(b) - 16 : int'(b);
    return 8'(ea * eb);
  endfunction

  initial begin
    logic [7:0] prod;
    int lat, busyCycles, pulses, firstPos, secondPos;

    testsRun = 0;
    testsFailed = 0;

    // Reset with start already high: the first edge after release must start the multiply.
    reset = 1'b1;
    start = 1'b1;
    signed_mode = 1'b0;
    A = 4'd5;
    B = 4'd6;
    repeat (2) @(negedge clk);
    checkOutput("reset O", 32'(O), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset Finish", 32'(Finish), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitFinish(lat, busyCycles);
    checkOutput("start through reset latency", 32'(lat), 32'd5);
    checkOutput("start through reset O", 32'(O), 32'h1E);

    // Test 1
    applyStimulus(1'b0, 4'd15, 4'd15, prod, lat, busyCycles);
    checkOutput("15x15 O", 32'(prod), 32'hE1);
    checkOutput("15x15 latency", 32'(lat), 32'd5);
    checkOutput("15x15 busy cycles", 32'(busyCycles), 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("O holds", 32'(O), 32'hE1);
    checkOutput("Finish single pulse", 32'(Finish), 32'h0);

    // Test 2
    applyStimulus(1'b1, 4'h8, 4'h8, prod, lat, busyCycles);
    checkOutput("-8x-8 O", 32'(prod), 32'h40);
    applyStimulus(1'b1, 4'hD, 4'h5, prod, lat, busyCycles);
    checkOutput("-3x5 O", 32'(prod), 32'hF1);
    checkOutput("-3x5 latency", 32'(lat), 32'd5);

    // Test 3
    applyStimulus(1'b0, 4'd0, 4'd9, prod, lat, busyCycles);
    checkOutput("0x9 O", 32'(prod), 32'h00);
    checkOutput("0x9 latency", 32'(lat), 32'd5);
    applyStimulus(1'b0, 4'd9, 4'd0, prod, lat, busyCycles);
    checkOutput("9x0 O", 32'(prod), 32'h00);
    checkOutput("9x0 latency", 32'(lat), 32'd5);

    // Test 4: start held high, expect a result every 6 cycles.
    @(negedge clk);
    signed_mode = 1'b0;
    A = 4'd3;
    B = 4'd4;
    start = 1'b1;
    @(posedge clk);
    pulses = 0;
    firstPos = -1;
    secondPos = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (Finish) begin
        pulses++;
        if (firstPos < 0) firstPos = k;
        else if (secondPos < 0) secondPos = k;
        checkOutput("held start O", 32'(O), 32'h0C);
      end
    end
    start = 1'b0;
    checkOutput("held start pulses", 32'(pulses), 32'd3);
    checkOutput("held start first", 32'(firstPos), 32'd5);
    checkOutput("held start period", 32'(secondPos - firstPos), 32'd6);
    repeat (10) @(negedge clk);

    // Test 5: reset at the second CALC edge aborts the operation.
    A = 4'd7;
    B = 4'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort O", 32'(O), 32'h00);
    checkOutput("abort busy", 32'(busy), 32'h0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (Finish) pulses++;
      @(negedge clk);
    end
    checkOutput("abort no Finish", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 4'd2, 4'd3, prod, lat, busyCycles);
    checkOutput("2x3 O", 32'(prod), 32'h06);

    // Test 6: all operand pairs in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(m[0], 4'(a), 4'(b), prod, lat, busyCycles);
          checkOutput($sformatf("sweep m%0d a%0d b%0d", m, a, b), 32'(prod),
                      32'(modelProduct(m[0], 4'(a), 4'(b))));
          if (lat != 5) checkOutput($sformatf("sweep latency m%0d a%0d b%0d", m, a, b), 32'(lat), 32'd5);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
